// File: rtl/fb_double_buffer_if.sv
// fb_double_buffer_if -- bus bundle for the double-buffered frame store.
//
// Groups the read port, write port, swap control and clear (fill) control
// of fb_double_buffer. Clock and reset stay as plain module ports.
//
// Parameters:
//   DATA_W  pixel word width
//   ADDR_W  per-bank pixel address width
//
// Modports:
//   slave   the frame store (fb_double_buffer)
//   master  the client driving reads, writes, swaps and fills
interface fb_double_buffer_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 17
);

  // Read port (front bank)
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;

  // Write port (back bank)
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  // Bank swap control
  logic              swap_req;
  logic              vsync;
  logic              swap_pending;
  logic              front_sel;

  // Back-bank fill control
  logic              clear_start;
  logic [DATA_W-1:0] clear_color;
  logic              clear_busy;

  modport slave (
    input  rd_en, rd_addr, wr_en, wr_addr, wr_data,
    input  swap_req, vsync, clear_start, clear_color,
    output rd_data, rd_valid, swap_pending, front_sel, clear_busy
  );

  modport master (
    output rd_en, rd_addr, wr_en, wr_addr, wr_data,
    output swap_req, vsync, clear_start, clear_color,
    input  rd_data, rd_valid, swap_pending, front_sel, clear_busy
  );

endinterface

// File: rtl/fb_double_buffer.sv
// fb_double_buffer -- two-bank frame store with vsync-aligned bank swap.
//
// One bank (front_sel) is displayed through the read port, the other bank
// is written through the write port. A swap request arms a bank swap that
// takes effect on the next vsync strobe. An optional fill engine paints the
// whole back bank with a single colour, one pixel per cycle.
//
// Configuration macro:
//   FB_DOUBLE_BUFFER_CLEAR_EN  when defined, builds the fill engine
//                              (IDLE/FILL FSM); when undefined, clear_start
//                              and clear_color are ignored and clear_busy is 0.
//
// Ports:
//   clk_sys  single clock, all logic on the rising edge
//   rst      synchronous active-high reset (memory contents are kept)
//   bus      fb_double_buffer_if.slave:
//            rd_en/rd_addr -> rd_data/rd_valid   one-cycle read of front bank
//            wr_en/wr_addr/wr_data                write to back bank
//            swap_req/vsync -> swap_pending/front_sel
//            clear_start/clear_color -> clear_busy
module fb_double_buffer #(
  parameter int W      = 320,
  parameter int H      = 240,
  parameter int DATA_W = 16,
  parameter int ADDR_W = 17
) (
  input  logic               clk_sys,
  input  logic               rst,
  fb_double_buffer_if.slave  bus
);

  localparam int unsigned      NPIX       = W * H;
  localparam int               IDX_W      = $clog2(2 * NPIX);
  localparam int               AW1        = ADDR_W + 1;
  // Pixel count held one bit wider than the address so 2**ADDR_W fits.
  localparam logic [AW1-1:0]   NPIX_A     = AW1'(NPIX);
  localparam logic [IDX_W-1:0] BANK1_BASE = IDX_W'(NPIX);

  // Both banks live in one array so a single write port can serve the
  // client writes and the fill engine.
  logic [DATA_W-1:0] mem [0:2*NPIX-1];

  // Flat word index of pixel addr inside the given bank.
  function automatic logic [IDX_W-1:0] bank_index(input logic bank,
                                                  input logic [ADDR_W-1:0] addr);
    bank_index = IDX_W'(addr) + (bank ? BANK1_BASE : {IDX_W{1'b0}});
  endfunction

  logic              front_sel_q,    front_sel_d;
  logic              swap_pending_q, swap_pending_d;
  logic              rd_valid_q,     rd_valid_d;
  logic [DATA_W-1:0] rd_data_q,      rd_data_d;

  logic              clear_busy_s;
  logic              rd_in_range_s;
  logic              wr_in_range_s;
  logic              mem_we_s;
  logic [IDX_W-1:0]  mem_widx_s;
  logic [DATA_W-1:0] mem_wdata_s;

`ifdef FB_DOUBLE_BUFFER_CLEAR_EN
  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_FILL = 1'b1
  } fill_state_e;

  localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(NPIX - 1);

  fill_state_e       state_q,       state_d;
  logic              clear_busy_q,  clear_busy_d;
  logic [ADDR_W-1:0] fill_addr_q,   fill_addr_d;
  logic [DATA_W-1:0] fill_color_q,  fill_color_d;

  assign clear_busy_s = clear_busy_q;

  // Fill FSM next state: a fill starts only when no swap is armed, then
  // walks the back bank from address 0 up to the last pixel.
  always_comb begin
    state_d      = state_q;
    clear_busy_d = clear_busy_q;
    fill_addr_d  = fill_addr_q;
    fill_color_d = fill_color_q;
    case (state_q)
      S_IDLE: begin
        if (bus.clear_start && !swap_pending_q) begin
          state_d      = S_FILL;
          clear_busy_d = 1'b1;
          fill_addr_d  = {ADDR_W{1'b0}};
          fill_color_d = bus.clear_color;
        end else begin
          state_d      = S_IDLE;
          clear_busy_d = 1'b0;
        end
      end
      S_FILL: begin
        if (fill_addr_q == LAST_A) begin
          state_d      = S_IDLE;
          clear_busy_d = 1'b0;
        end else begin
          fill_addr_d  = fill_addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_d      = S_IDLE;
        clear_busy_d = 1'b0;
      end
    endcase
  end

  // Fill FSM registers.
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state_q      <= S_IDLE;
      clear_busy_q <= 1'b0;
      fill_addr_q  <= {ADDR_W{1'b0}};
      fill_color_q <= {DATA_W{1'b0}};
    end else begin
      state_q      <= state_d;
      clear_busy_q <= clear_busy_d;
      fill_addr_q  <= fill_addr_d;
      fill_color_q <= fill_color_d;
    end
  end
`else
  assign clear_busy_s = 1'b0;
`endif

  assign rd_in_range_s = ({1'b0, bus.rd_addr} < NPIX_A);
  assign wr_in_range_s = ({1'b0, bus.wr_addr} < NPIX_A);

  // Read path: front bank sampled in the request cycle; out-of-range
  // addresses return zero; data holds between reads.
  always_comb begin
    rd_valid_d = bus.rd_en;
    rd_data_d  = rd_data_q;
    if (bus.rd_en) begin
      if (rd_in_range_s) begin
        rd_data_d = mem[bank_index(front_sel_q, bus.rd_addr)];
      end else begin
        rd_data_d = {DATA_W{1'b0}};
      end
    end else begin
      rd_data_d = rd_data_q;
    end
  end

  // Write port arbitration: reset blocks all writes, the fill engine owns
  // the port while busy, otherwise in-range client writes go to the back bank.
  always_comb begin
    mem_we_s    = 1'b0;
    mem_widx_s  = {IDX_W{1'b0}};
    mem_wdata_s = {DATA_W{1'b0}};
    if (rst) begin
      mem_we_s = 1'b0;
    end else if (clear_busy_s) begin
      mem_we_s    = 1'b1;
`ifdef FB_DOUBLE_BUFFER_CLEAR_EN
      mem_widx_s  = bank_index(~front_sel_q, fill_addr_q);
      mem_wdata_s = fill_color_q;
`endif
    end else if (bus.wr_en && wr_in_range_s) begin
      mem_we_s    = 1'b1;
      mem_widx_s  = bank_index(~front_sel_q, bus.wr_addr);
      mem_wdata_s = bus.wr_data;
    end else begin
      mem_we_s = 1'b0;
    end
  end

  // Swap control: a vsync with an armed swap flips the banks unless a fill
  // is running, in which case the swap waits for a later vsync.
  always_comb begin
    front_sel_d    = front_sel_q;
    swap_pending_d = swap_pending_q;
    if (swap_pending_q && bus.vsync && !clear_busy_s) begin
      front_sel_d    = ~front_sel_q;
      swap_pending_d = 1'b0;
    end else if (bus.swap_req) begin
      swap_pending_d = 1'b1;
    end else begin
      swap_pending_d = swap_pending_q;
    end
  end

  // Frame memory write port (contents are not reset).
  always_ff @(posedge clk_sys) begin
    if (mem_we_s) begin
      mem[mem_widx_s] <= mem_wdata_s;
    end
  end

  // Control and read-output registers.
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      front_sel_q    <= 1'b0;
      swap_pending_q <= 1'b0;
      rd_valid_q     <= 1'b0;
      rd_data_q      <= {DATA_W{1'b0}};
    end else begin
      front_sel_q    <= front_sel_d;
      swap_pending_q <= swap_pending_d;
      rd_valid_q     <= rd_valid_d;
      rd_data_q      <= rd_data_d;
    end
  end

  assign bus.front_sel    = front_sel_q;
  assign bus.swap_pending = swap_pending_q;
  assign bus.rd_valid     = rd_valid_q;
  assign bus.rd_data      = rd_data_q;
  assign bus.clear_busy   = clear_busy_s;

endmodule

// File: tb/tb_fb_double_buffer.sv
// tb_fb_double_buffer -- self-checking bench for fb_double_buffer (W=4, H=2).
// A cycle-level reference model (plain arrays and counters) predicts every
// output; directed scenarios plus a randomized run compare DUT to model.
module tb_fb_double_buffer;

  localparam int W      = 4;
  localparam int H      = 2;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 4;
  localparam int NPIX   = W * H;

  logic clk_sys = 1'b0;
  logic rst     = 1'b1;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  fb_double_buffer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  fb_double_buffer #(
    .W(W), .H(H), .DATA_W(DATA_W), .ADDR_W(ADDR_W)
  ) dut (
    .clk_sys(clk_sys),
    .rst    (rst),
    .bus    (bus)
  );

  always #5 clk_sys = ~clk_sys;

  // Reference model state
  logic [15:0] mem_m [0:2*NPIX-1];
  bit          front_m, pend_m, busy_m, rdv_m;
  logic [15:0] rdd_m;
  int          fill_next_m;
  logic [15:0] fill_color_m;

  task automatic model_tick();
    bit busy_old  = busy_m;
    bit pend_old  = pend_m;
    bit front_old = front_m;
    if (rst) begin
      front_m = 1'b0; pend_m = 1'b0; rdv_m = 1'b0; rdd_m = 16'h0; busy_m = 1'b0;
      return;
    end
    if (bus.rd_en) begin
      rdv_m = 1'b1;
      if (int'(bus.rd_addr) < NPIX) rdd_m = mem_m[int'(front_old) * NPIX + int'(bus.rd_addr)];
      else rdd_m = 16'h0;
    end else begin
      rdv_m = 1'b0;
    end
    if (busy_old) begin
      mem_m[(1 - int'(front_old)) * NPIX + fill_next_m] = fill_color_m;
      fill_next_m++;
      if (fill_next_m == NPIX) busy_m = 1'b0;
    end else if (bus.wr_en && int'(bus.wr_addr) < NPIX) begin
      mem_m[(1 - int'(front_old)) * NPIX + int'(bus.wr_addr)] = bus.wr_data;
    end
    if (pend_old && bus.vsync && !busy_old) begin
      front_m = !front_old;
      pend_m  = 1'b0;
    end else if (bus.swap_req) begin
      pend_m = 1'b1;
    end
`ifdef FB_DOUBLE_BUFFER_CLEAR_EN
    if (!busy_old && bus.clear_start && !pend_old) begin
      busy_m       = 1'b1;
      fill_next_m  = 0;
      fill_color_m = bus.clear_color;
    end
`endif
  endtask

  task automatic step();
    @(posedge clk_sys);
    model_tick();
    #1;
  endtask

  task automatic idle_inputs();
    bus.rd_en = 1'b0; bus.rd_addr = '0;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.swap_req = 1'b0; bus.vsync = 1'b0;
    bus.clear_start = 1'b0; bus.clear_color = '0;
  endtask

  task automatic do_swap();
    bus.swap_req = 1'b1; step(); bus.swap_req = 1'b0;
    bus.vsync    = 1'b1; step(); bus.vsync    = 1'b0;
  endtask

  task automatic fill_back_random();
    for (int a = 0; a < NPIX; a++) begin
      bus.wr_en = 1'b1; bus.wr_addr = a[ADDR_W-1:0]; bus.wr_data = 16'($urandom);
      step();
    end
    bus.wr_en = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1; step(); step();
    chk_cnt++; if (bus.front_sel !== front_m) $display("FAIL reset_front_sel: got %0d want %0d", bus.front_sel, front_m); else pass_cnt++;
    chk_cnt++; if (bus.swap_pending !== pend_m) $display("FAIL reset_swap_pending: got %0d want %0d", bus.swap_pending, pend_m); else pass_cnt++;
    chk_cnt++; if (bus.rd_valid !== rdv_m) $display("FAIL reset_rd_valid: got %0d want %0d", bus.rd_valid, rdv_m); else pass_cnt++;
    chk_cnt++; if (bus.rd_data !== rdd_m) $display("FAIL reset_rd_data: got %h want %h", bus.rd_data, rdd_m); else pass_cnt++;
    chk_cnt++; if (bus.clear_busy !== busy_m) $display("FAIL reset_clear_busy: got %0d want %0d", bus.clear_busy, busy_m); else pass_cnt++;
    rst = 1'b0;
    // Give both banks known contents.
    fill_back_random(); do_swap();
    fill_back_random(); do_swap();
  endtask

  task automatic test_basic_swap();
    bus.wr_en = 1'b1; bus.wr_addr = 4'd3; bus.wr_data = 16'hABCD; step();
    bus.wr_en = 1'b0;
    bus.swap_req = 1'b1; step(); bus.swap_req = 1'b0;
    chk_cnt++; if (bus.swap_pending !== pend_m) $display("FAIL swap_armed: got %0d want %0d", bus.swap_pending, pend_m); else pass_cnt++;
    bus.vsync = 1'b1; step(); bus.vsync = 1'b0;
    chk_cnt++; if (bus.front_sel !== front_m) $display("FAIL swap_front_sel: got %0d want %0d", bus.front_sel, front_m); else pass_cnt++;
    bus.rd_en = 1'b1; bus.rd_addr = 4'd3; step(); bus.rd_en = 1'b0;
    chk_cnt++; if (bus.rd_valid !== 1'b1) $display("FAIL swap_rd_valid: got %0d want 1", bus.rd_valid); else pass_cnt++;
    chk_cnt++; if (bus.rd_data !== rdd_m) $display("FAIL swap_rd_data: got %h want %h", bus.rd_data, rdd_m); else pass_cnt++;
    step();
    chk_cnt++; if (bus.rd_valid !== rdv_m) $display("FAIL rd_valid_drop: got %0d want %0d", bus.rd_valid, rdv_m); else pass_cnt++;
    chk_cnt++; if (bus.rd_data !== rdd_m) $display("FAIL rd_data_hold: got %h want %h", bus.rd_data, rdd_m); else pass_cnt++;
  endtask

  task automatic test_same_cycle_swap();
    bus.swap_req = 1'b1; bus.vsync = 1'b1; step();
    bus.swap_req = 1'b0; bus.vsync = 1'b0;
    chk_cnt++; if (bus.front_sel !== front_m) $display("FAIL same_cycle_front: got %0d want %0d", bus.front_sel, front_m); else pass_cnt++;
    chk_cnt++; if (bus.swap_pending !== pend_m) $display("FAIL same_cycle_pending: got %0d want %0d", bus.swap_pending, pend_m); else pass_cnt++;
    step(); step();
    bus.vsync = 1'b1; step(); bus.vsync = 1'b0;
    chk_cnt++; if (bus.front_sel !== front_m) $display("FAIL next_vsync_front: got %0d want %0d", bus.front_sel, front_m); else pass_cnt++;
    chk_cnt++; if (bus.swap_pending !== pend_m) $display("FAIL next_vsync_pending: got %0d want %0d", bus.swap_pending, pend_m); else pass_cnt++;
  endtask

  task automatic test_out_of_range();
    bus.rd_en = 1'b1; bus.rd_addr = 4'd8; step(); bus.rd_en = 1'b0;
    chk_cnt++; if (bus.rd_valid !== 1'b1) $display("FAIL oob_rd_valid: got %0d want 1", bus.rd_valid); else pass_cnt++;
    chk_cnt++; if (bus.rd_data !== 16'h0) $display("FAIL oob_rd_data: got %h want 0000", bus.rd_data); else pass_cnt++;
    bus.wr_en = 1'b1; bus.wr_addr = 4'd8; bus.wr_data = 16'hDEAD; step(); bus.wr_en = 1'b0;
    for (int b = 0; b < 2; b++) begin
      for (int a = 0; a < NPIX; a++) begin
        bus.rd_en = 1'b1; bus.rd_addr = a[ADDR_W-1:0]; step();
        chk_cnt++; if (bus.rd_data !== rdd_m) $display("FAIL oob_bank_word[%0d]: got %h want %h", a, bus.rd_data, rdd_m); else pass_cnt++;
      end
      bus.rd_en = 1'b0;
      do_swap();
    end
  endtask

`ifdef FB_DOUBLE_BUFFER_CLEAR_EN
  task automatic test_clear();
    int busy_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      bus.clear_start = (i == 0); bus.clear_color = 16'h1234;
      bus.wr_en = (i == 1); bus.wr_addr = 4'd0; bus.wr_data = 16'h5555;
      step();
      if (bus.clear_busy === 1'b1) busy_cnt++;
      chk_cnt++; if (bus.clear_busy !== busy_m) $display("FAIL clear_busy[%0d]: got %0d want %0d", i, bus.clear_busy, busy_m); else pass_cnt++;
    end
    bus.clear_start = 1'b0; bus.wr_en = 1'b0;
    chk_cnt++; if (busy_cnt !== NPIX) $display("FAIL clear_busy_cycles: got %0d want %0d", busy_cnt, NPIX); else pass_cnt++;
    do_swap();
    for (int a = 0; a < NPIX; a++) begin
      bus.rd_en = 1'b1; bus.rd_addr = a[ADDR_W-1:0]; step();
      chk_cnt++; if (bus.rd_data !== 16'h1234) $display("FAIL clear_word[%0d]: got %h want 1234", a, bus.rd_data); else pass_cnt++;
    end
    bus.rd_en = 1'b0;
  endtask

  task automatic test_clear_reset();
    rst = 1'b1; step(); rst = 1'b0;
    fill_back_random();
    for (int i = 0; i < 6; i++) begin
      bus.clear_start = (i == 0); bus.clear_color = 16'h1234;
      bus.swap_req = (i == 2);
      rst = (i == 5);
      step();
    end
    rst = 1'b0; bus.clear_start = 1'b0; bus.swap_req = 1'b0;
    chk_cnt++; if (bus.clear_busy !== 1'b0) $display("FAIL abort_clear_busy: got %0d want 0", bus.clear_busy); else pass_cnt++;
    chk_cnt++; if (bus.front_sel !== 1'b0) $display("FAIL abort_front_sel: got %0d want 0", bus.front_sel); else pass_cnt++;
    chk_cnt++; if (bus.swap_pending !== 1'b0) $display("FAIL abort_swap_pending: got %0d want 0", bus.swap_pending); else pass_cnt++;
    do_swap();
    for (int a = 0; a < NPIX; a++) begin
      bus.rd_en = 1'b1; bus.rd_addr = a[ADDR_W-1:0]; step();
      chk_cnt++; if (bus.rd_data !== rdd_m) $display("FAIL abort_word[%0d]: got %h want %h", a, bus.rd_data, rdd_m); else pass_cnt++;
    end
    bus.rd_en = 1'b0;
  endtask
`else
  task automatic test_clear_disabled();
    bus.clear_start = 1'b1; bus.clear_color = 16'h1234; step();
    bus.clear_start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk_cnt++; if (bus.clear_busy !== 1'b0) $display("FAIL disabled_clear_busy[%0d]: got %0d want 0", i, bus.clear_busy); else pass_cnt++;
      step();
    end
    do_swap();
    for (int a = 0; a < NPIX; a++) begin
      bus.rd_en = 1'b1; bus.rd_addr = a[ADDR_W-1:0]; step();
      chk_cnt++; if (bus.rd_data !== rdd_m) $display("FAIL disabled_back_word[%0d]: got %h want %h", a, bus.rd_data, rdd_m); else pass_cnt++;
    end
    bus.rd_en = 1'b0;
  endtask
`endif

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      bus.rd_en       = 1'($urandom_range(0, 1));
      bus.rd_addr     = 4'($urandom_range(0, 9));
      bus.wr_en       = 1'($urandom_range(0, 1));
      bus.wr_addr     = 4'($urandom_range(0, 9));
      bus.wr_data     = 16'($urandom);
      bus.swap_req    = ($urandom_range(0, 7) == 0);
      bus.vsync       = ($urandom_range(0, 5) == 0);
      bus.clear_start = ($urandom_range(0, 19) == 0);
      bus.clear_color = 16'($urandom);
      rst             = ($urandom_range(0, 149) == 0);
      step();
      chk_cnt++; if (bus.rd_valid !== rdv_m) $display("FAIL rand_rd_valid@%0d: got %0d want %0d", n, bus.rd_valid, rdv_m); else pass_cnt++;
      chk_cnt++; if (bus.rd_data !== rdd_m) $display("FAIL rand_rd_data@%0d: got %h want %h", n, bus.rd_data, rdd_m); else pass_cnt++;
      chk_cnt++; if (bus.front_sel !== front_m) $display("FAIL rand_front_sel@%0d: got %0d want %0d", n, bus.front_sel, front_m); else pass_cnt++;
      chk_cnt++; if (bus.swap_pending !== pend_m) $display("FAIL rand_swap_pending@%0d: got %0d want %0d", n, bus.swap_pending, pend_m); else pass_cnt++;
      chk_cnt++; if (bus.clear_busy !== busy_m) $display("FAIL rand_clear_busy@%0d: got %0d want %0d", n, bus.clear_busy, busy_m); else pass_cnt++;
    end
    rst = 1'b0;
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_basic_swap();
    test_same_cycle_swap();
    test_out_of_range();
`ifdef FB_DOUBLE_BUFFER_CLEAR_EN
    test_clear();
    test_clear_reset();
`else
    test_clear_disabled();
`endif
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/fb_double_buffer.md
FB_DOUBLE_BUFFER -- requirements
Module: fb_double_buffer

Interface
REQ-001 SHALL have parameter W, default 320, frame width in pixels.
REQ-002 SHALL have parameter H, default 240, frame height in pixels.
REQ-003 SHALL have parameter DATA_W, default 16, pixel word width.
REQ-004 SHALL have parameter ADDR_W, default 17, per-bank pixel address width; W*H <= 2**ADDR_W.
REQ-005 SHALL have port clk_sys  input  1  single clock; all logic on rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port rd_en  input  1  read request, front bank.
REQ-008 SHALL have port rd_addr  input  ADDR_W  read pixel address.
REQ-009 SHALL have port rd_data  output  DATA_W  read pixel data.
REQ-010 SHALL have port rd_valid  output  1  rd_data valid strobe.
REQ-011 SHALL have port wr_en  input  1  write request, back bank.
REQ-012 SHALL have port wr_addr  input  ADDR_W  write pixel address.
REQ-013 SHALL have port wr_data  input  DATA_W  write pixel data.
REQ-014 SHALL have port swap_req  input  1  one-cycle pulse: back bank complete.
REQ-015 SHALL have port vsync  input  1  one-cycle frame-boundary strobe.
REQ-016 SHALL have port swap_pending  output  1  swap armed, waiting for vsync.
REQ-017 SHALL have port front_sel  output  1  bank currently displayed (0/1).
REQ-018 SHALL have port clear_start  input  1  one-cycle pulse: fill back bank.
REQ-019 SHALL have port clear_color  input  DATA_W  fill value, sampled on clear_start.
REQ-020 SHALL have port clear_busy  output  1  fill in progress.

Function
REQ-021 SHALL hold 2*W*H words; bank b, pixel a at index b*W*H+a; block RAM inference.
REQ-022 SHALL read bank front_sel as sampled in the rd_en cycle; rd_data and rd_valid=1 exactly 1 cycle later; rd_valid=0 otherwise; rd_data holds last value when rd_valid=0.
REQ-023 SHALL return rd_data=0 (rd_valid=1) for rd_addr >= W*H.
REQ-024 SHALL write wr_data to bank ~front_sel when wr_en=1, wr_addr < W*H, clear_busy=0; other writes dropped silently.
REQ-025 SHALL set swap_pending on swap_req; swap_req while pending has no extra effect.
REQ-026 SHALL, on vsync with swap_pending=1 and clear_busy=0, toggle front_sel and clear swap_pending in the same edge; new front_sel visible next cycle.
REQ-027 SHALL, for swap_req and vsync in the same cycle with swap_pending=0, set pending only; swap occurs at the following vsync.
REQ-028 SHALL, on vsync while clear_busy=1, keep swap deferred to the first vsync after clear_busy falls.
REQ-029 SHALL implement clear FSM states IDLE, FILL: IDLE->FILL on clear_start with swap_pending=0; FILL writes clear_color to back bank addresses 0..W*H-1, one per cycle, ascending; FILL->IDLE after address W*H-1.
REQ-030 SHALL assert clear_busy throughout FILL (exactly W*H cycles, from the cycle after clear_start); ignore clear_start while busy or while swap_pending=1.
REQ-031 SHALL allow simultaneous read and write/fill every cycle with no stall.

Reset
REQ-032 SHALL on rst: front_sel=0, swap_pending=0, rd_valid=0, rd_data=0, clear_busy=0, FSM=IDLE; memory contents not reset.
REQ-033 SHALL abort an in-progress fill or armed swap on rst; partial fill contents remain.

Configuration
REQ-034 SHALL gate the fill engine with macro FB_DOUBLE_BUFFER_CLEAR_EN.
REQ-035 SHALL, with FB_DOUBLE_BUFFER_CLEAR_EN defined, implement REQ-028..REQ-030 fully.
REQ-036 SHALL, without it, keep ports clear_start/clear_color, ignore them, tie clear_busy=0, omit FSM logic.

Verification (W=4, H=2, DATA_W=16)
REQ-037 SHALL cover: write 0xABCD to addr 3 (back=bank1), swap_req, vsync, then rd_en addr 3 -> rd_valid=1, rd_data=0xABCD one cycle later, front_sel=1.
REQ-038 SHALL cover: swap_req and vsync same cycle -> front_sel unchanged, swap_pending=1; next vsync -> front_sel toggles, swap_pending=0.
REQ-039 SHALL cover: clear_start, clear_color=0x1234 -> clear_busy high 8 cycles; concurrent wr_en to addr 0 dropped; after swap all 8 reads return 0x1234.
REQ-040 SHALL cover: rd_en addr 8 -> rd_data=0, rd_valid=1; wr_en addr 8 -> no bank word changes.
REQ-041 SHALL cover: rst asserted during fill cycle 4 -> next cycle clear_busy=0, front_sel=0, swap_pending=0; addrs 0..3 hold 0x1234, 4..7 unchanged.
REQ-042 SHALL cover: macro undefined, clear_start pulse -> clear_busy stays 0, back bank unchanged.
